// File: rtl/read_return_sequencer_pkg.sv
// Shared types and defaults for the read-return sequencer: backend
// controller count, bc id type and default parameter values.
package read_return_sequencer_pkg;

  // Number of backend controllers whose return buffers are sequenced.
  localparam int NUM_BC = 4;

  // Width of a backend controller id.
  localparam int BC_ID_W = 2;

  // Default width of one global-controller read data word.
  localparam int DEFAULT_DATA_W = 32;

  // Default outstanding-read order queue depth (power of 2, >= 2).
  localparam int DEFAULT_ORDER_DEPTH = 16;

  // Default cycles the head read may wait before the watchdog fires.
  localparam int DEFAULT_TIMEOUT_CYC = 1024;

  // Backend controller id carried through the order queue.
  typedef logic [BC_ID_W-1:0] bc_id_t;

endpackage : read_return_sequencer_pkg

// File: rtl/read_return_sequencer_if.sv
// Bundle of the issue log, backend return and core read-data signals of
// the read-return sequencer. The slave modport is the sequencer itself,
// the master modport is the surrounding controller (dispatcher, backend
// return buffers and core).
interface read_return_sequencer_if #(
  parameter int DATA_W = read_return_sequencer_pkg::DEFAULT_DATA_W
) ();
  import read_return_sequencer_pkg::*;

  // Issue log from the dispatcher
  logic              i_issue_valid;
  bc_id_t            i_issue_bc;
  logic              o_order_full;
  logic              o_order_empty;

  // Backend return buffers (first-word-fall-through heads)
  logic [NUM_BC-1:0] i_returned_data_valid;
  logic [DATA_W-1:0] i_returned_data_bc0;
  logic [DATA_W-1:0] i_returned_data_bc1;
  logic [DATA_W-1:0] i_returned_data_bc2;
  logic [DATA_W-1:0] i_returned_data_bc3;
  logic [NUM_BC-1:0] o_backend_controller_ren;

  // In-order read data to the core
  logic              o_read_data_valid;
  logic [DATA_W-1:0] o_read_data;

  // Sticky error flags
  logic              o_overflow_err;
  logic              o_timeout_err;

  modport slave (
    input  i_issue_valid,
    input  i_issue_bc,
    output o_order_full,
    output o_order_empty,
    input  i_returned_data_valid,
    input  i_returned_data_bc0,
    input  i_returned_data_bc1,
    input  i_returned_data_bc2,
    input  i_returned_data_bc3,
    output o_backend_controller_ren,
    output o_read_data_valid,
    output o_read_data,
    output o_overflow_err,
    output o_timeout_err
  );

  modport master (
    output i_issue_valid,
    output i_issue_bc,
    input  o_order_full,
    input  o_order_empty,
    output i_returned_data_valid,
    output i_returned_data_bc0,
    output i_returned_data_bc1,
    output i_returned_data_bc2,
    output i_returned_data_bc3,
    input  o_backend_controller_ren,
    input  o_read_data_valid,
    input  o_read_data,
    input  o_overflow_err,
    input  o_timeout_err
  );

endinterface : read_return_sequencer_if

// File: rtl/read_return_sequencer_bc_order_fifo.sv
// Synchronous FIFO of bc ids recording the issue order of outstanding
// reads. The head entry is visible combinationally so the pop decision
// can be made in the same cycle. Push and pop may happen together; a push
// into a full queue is only taken when the head pops in the same cycle.
// full/empty are registered so they do not depend on this cycle's inputs.
module bc_order_fifo
  import read_return_sequencer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_ORDER_DEPTH
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  bc_id_t push_id,
  input  logic   pop,
  output bc_id_t head,
  output logic   full,
  output logic   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  bc_id_t           mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             full_reg;
  logic             empty_reg;
  logic             do_push;
  logic             do_pop;

  // Guard against misuse: never pop an empty queue, never overwrite a full one.
  assign do_pop  = pop && !empty_reg;
  assign do_push = push && (!full_reg || do_pop);

  // Occupancy after this cycle's push/pop; simultaneous push+pop keeps it.
  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  // Pointers, occupancy and registered full/empty flags; pointers wrap
  // naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_next;
      full_reg  <= (count_next == CNT_MAX);
      empty_reg <= (count_next == '0);
    end
  end

  // Entry storage; cleared on reset so the head never shows X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_id;
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign full  = full_reg;
  assign empty = empty_reg;

endmodule : bc_order_fifo

// File: rtl/read_return_sequencer.sv
// Returns read data from the four backend controllers to the core in
// command-issue order. The order queue holds the bc id of every
// outstanding read; the head bc's return buffer is popped as soon as it
// is non-empty, and the popped word is registered onto o_read_data with a
// one-cycle valid pulse. Returns from non-head controllers wait in their
// own buffers. Also flags order-queue overflow and a stalled head read.
module read_return_sequencer
  import read_return_sequencer_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int ORDER_DEPTH = DEFAULT_ORDER_DEPTH,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  read_return_sequencer_if.slave bus
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYC);

  bc_id_t            head;
  logic              order_empty;
  logic              order_full;
  logic              pop;
  logic              push;
  logic              drop;
  logic [NUM_BC-1:0] ren;
  logic [DATA_W-1:0] ret_data [NUM_BC];
  logic [DATA_W-1:0] sel_data;

  logic [DATA_W-1:0] read_data_reg;
  logic              read_data_valid_reg;
  logic              overflow_reg;
  logic              timeout_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [WAIT_W-1:0] wait_cnt_next;

  assign ret_data[0] = bus.i_returned_data_bc0;
  assign ret_data[1] = bus.i_returned_data_bc1;
  assign ret_data[2] = bus.i_returned_data_bc2;
  assign ret_data[3] = bus.i_returned_data_bc3;

  // Strict in-order: only the head bc can be popped, and only when its
  // return buffer already holds data.
  assign pop  = !order_empty && bus.i_returned_data_valid[head];

  // A full queue still accepts a push in the cycle its head leaves.
  assign push = bus.i_issue_valid && (!order_full || pop);
  assign drop = bus.i_issue_valid && order_full && !pop;

  bc_order_fifo #(
    .DEPTH (ORDER_DEPTH)
  ) u_order_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .push    (push),
    .push_id (bus.i_issue_bc),
    .pop     (pop),
    .head    (head),
    .full    (order_full),
    .empty   (order_empty)
  );

  // One-hot read enable toward the head bc, zero when nothing pops.
  for (genvar gi = 0; gi < NUM_BC; gi++) begin : g_ren
    assign ren[gi] = pop && (head == bc_id_t'(gi));
  end

  assign sel_data = ret_data[head];

  // Watchdog: counts cycles the head read has waited, saturating at the
  // limit; cleared whenever the head pops or nothing is outstanding.
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (pop || order_empty) begin
      wait_cnt_next = '0;
    end else if (wait_cnt_reg != WAIT_LIMIT) begin
      wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
    end
  end

  // Output data register, valid pulse, watchdog counter and sticky errors.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      read_data_reg       <= '0;
      read_data_valid_reg <= 1'b0;
      overflow_reg        <= 1'b0;
      timeout_reg         <= 1'b0;
      wait_cnt_reg        <= '0;
    end else begin
      read_data_valid_reg <= pop;
      if (pop) begin
        read_data_reg <= sel_data;
      end
      if (drop) begin
        overflow_reg <= 1'b1;
      end
      wait_cnt_reg <= wait_cnt_next;
      if (wait_cnt_next == WAIT_LIMIT) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  assign bus.o_order_full             = order_full;
  assign bus.o_order_empty            = order_empty;
  assign bus.o_backend_controller_ren = ren;
  assign bus.o_read_data_valid        = read_data_valid_reg;
  assign bus.o_read_data              = read_data_reg;
  assign bus.o_overflow_err           = overflow_reg;
  assign bus.o_timeout_err            = timeout_reg;

endmodule : read_return_sequencer

// File: tb/tb_read_return_sequencer.sv
// Self-checking bench for read_return_sequencer: a streaming vector table
// plus hand-written sequences for reset, out-of-order returns, overflow,
// watchdog and asynchronous reset. Expected read data is queued when the
// read is issued and compared when the core sees o_read_data_valid.
module tb_read_return_sequencer;
  import read_return_sequencer_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int TO    = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  read_return_sequencer_if #(.DATA_W(DW)) bus ();

  read_return_sequencer #(
    .DATA_W      (DW),
    .ORDER_DEPTH (DEPTH),
    .TIMEOUT_CYC (TO)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q [$];

  typedef struct {
    logic       iv;
    bc_id_t     bc;
    logic [3:0] rv;
    logic [3:0] ren;
    logic       vld;
  } vec_t;

  vec_t stream_tbl [10];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, req);
  endtask

  task automatic drive(input logic iv, input bc_id_t bc, input logic [3:0] rv);
    bus.i_issue_valid         = iv;
    bus.i_issue_bc            = bc;
    bus.i_returned_data_valid = rv;
  endtask

  task automatic set_data(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                          input logic [DW-1:0] d2, input logic [DW-1:0] d3);
    bus.i_returned_data_bc0 = d0;
    bus.i_returned_data_bc1 = d1;
    bus.i_returned_data_bc2 = d2;
    bus.i_returned_data_bc3 = d3;
  endtask

  // Scoreboard side: every valid pulse must match the oldest expected word.
  task automatic monitor();
    logic [DW-1:0] e;
    if (bus.o_read_data_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", DW'(1), DW'(0));
      end else begin
        e = exp_q.pop_front();
        check("read_data", bus.o_read_data, e);
        $display("t=%0t core read 'h%0h (expected 'h%0h)", $time, bus.o_read_data, e);
      end
    end
  endtask

  // One cycle: inputs already driven; sample at negedge, then advance past the edge.
  task automatic step(input string name, input logic [3:0] exp_ren);
    @(negedge clk);
    monitor();
    check(name, DW'(bus.o_backend_controller_ren), DW'(exp_ren));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_empty"},    DW'(bus.o_order_empty), DW'(1));
    check({tag, "_full"},     DW'(bus.o_order_full), DW'(0));
    check({tag, "_ren"},      DW'(bus.o_backend_controller_ren), DW'(0));
    check({tag, "_valid"},    DW'(bus.o_read_data_valid), DW'(0));
    check({tag, "_data"},     bus.o_read_data, DW'(0));
    check({tag, "_overflow"}, DW'(bus.o_overflow_err), DW'(0));
    check({tag, "_timeout"},  DW'(bus.o_timeout_err), DW'(0));
  endtask

  initial begin
    stream_tbl[0] = '{1'b1, 2'd0, 4'b0000, 4'b0000, 1'b0};
    stream_tbl[1] = '{1'b1, 2'd1, 4'b0000, 4'b0000, 1'b0};
    stream_tbl[2] = '{1'b1, 2'd2, 4'b0000, 4'b0000, 1'b0};
    stream_tbl[3] = '{1'b1, 2'd3, 4'b0000, 4'b0000, 1'b0};
    stream_tbl[4] = '{1'b0, 2'd0, 4'b1111, 4'b0001, 1'b0};
    stream_tbl[5] = '{1'b0, 2'd0, 4'b1111, 4'b0010, 1'b1};
    stream_tbl[6] = '{1'b0, 2'd0, 4'b1111, 4'b0100, 1'b1};
    stream_tbl[7] = '{1'b0, 2'd0, 4'b1111, 4'b1000, 1'b1};
    stream_tbl[8] = '{1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1};
    stream_tbl[9] = '{1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0};

    // ---------------- reset ----------------
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 4'b0000);
    set_data('0, '0, '0, '0);
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) step("idle_ren", 4'b0000);
    check("idle_valid", DW'(bus.o_read_data_valid), DW'(0));

    // ---------------- out-of-order returns ----------------
    set_data(DW'('hA), '0, DW'('hB), '0);
    drive(1'b1, 2'd2, 4'b0000); exp_q.push_back(DW'('hB)); step("ooo_issue_bc2", 4'b0000);
    drive(1'b1, 2'd0, 4'b0000); exp_q.push_back(DW'('hA)); step("ooo_issue_bc0", 4'b0000);
    drive(1'b0, 2'd0, 4'b0001);
    for (int i = 0; i < 3; i++) step("ooo_bc0_blocked", 4'b0000);
    drive(1'b0, 2'd0, 4'b0101); step("ooo_ren_bc2", 4'b0100);
    drive(1'b0, 2'd0, 4'b0001); step("ooo_ren_bc0", 4'b0001);
    drive(1'b0, 2'd0, 4'b0000); step("ooo_idle", 4'b0000);
    step("ooo_idle2", 4'b0000);
    check("ooo_empty", DW'(bus.o_order_empty), DW'(1));
    check("ooo_scoreboard_drained", DW'(exp_q.size()), DW'(0));

    // ---------------- streaming (table driven) ----------------
    set_data(DW'('h100), DW'('h101), DW'('h102), DW'('h103));
    for (int r = 0; r < 10; r++) begin
      drive(stream_tbl[r].iv, stream_tbl[r].bc, stream_tbl[r].rv);
      if (stream_tbl[r].iv) exp_q.push_back(DW'('h100) + DW'(stream_tbl[r].bc));
      @(negedge clk);
      check($sformatf("stream_valid_row%0d", r), DW'(bus.o_read_data_valid), DW'(stream_tbl[r].vld));
      monitor();
      check($sformatf("stream_ren_row%0d", r), DW'(bus.o_backend_controller_ren), DW'(stream_tbl[r].ren));
      @(posedge clk);
      #1;
    end
    check("stream_scoreboard_drained", DW'(exp_q.size()), DW'(0));

    // ---------------- full / overflow ----------------
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, bc_id_t'(i % 4), 4'b0000);
      exp_q.push_back({16'(i), 16'(i % 4)});
      step("fill_ren", 4'b0000);
    end
    drive(1'b0, 2'd0, 4'b0000);
    check("fill_full", DW'(bus.o_order_full), DW'(1));
    check("fill_overflow_clear", DW'(bus.o_overflow_err), DW'(0));
    drive(1'b1, 2'd2, 4'b0000); step("drop_ren", 4'b0000);
    drive(1'b0, 2'd0, 4'b0000);
    check("drop_overflow", DW'(bus.o_overflow_err), DW'(1));
    check("drop_full", DW'(bus.o_order_full), DW'(1));
    check("stall_timeout", DW'(bus.o_timeout_err), DW'(1));
    set_data({16'd0, 16'd0}, {16'd0, 16'd1}, {16'd0, 16'd2}, {16'd0, 16'd3});
    drive(1'b1, 2'd0, 4'b0001);
    exp_q.push_back({16'(DEPTH), 16'(0)});
    step("full_push_pop_ren", 4'b0001);
    drive(1'b0, 2'd0, 4'b0000);
    check("full_push_pop_full", DW'(bus.o_order_full), DW'(1));
    for (int k = 1; k <= DEPTH; k++) begin
      set_data({16'(k), 16'd0}, {16'(k), 16'd1}, {16'(k), 16'd2}, {16'(k), 16'd3});
      drive(1'b0, 2'd0, 4'b1111);
      step("drain_ren", 4'(1 << (k % 4)));
    end
    drive(1'b0, 2'd0, 4'b0000);
    step("drain_tail", 4'b0000);
    check("drain_empty", DW'(bus.o_order_empty), DW'(1));
    check("drain_scoreboard", DW'(exp_q.size()), DW'(0));
    check("overflow_sticky", DW'(bus.o_overflow_err), DW'(1));

    // ---------------- watchdog ----------------
    #2 rst_n = 1'b0;
    #1;
    check("wd_reset_timeout", DW'(bus.o_timeout_err), DW'(0));
    check("wd_reset_overflow", DW'(bus.o_overflow_err), DW'(0));
    rst_n = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    set_data('0, DW'('hC), '0, '0);
    drive(1'b1, 2'd1, 4'b0000); exp_q.push_back(DW'('hC)); step("wd_issue", 4'b0000);
    drive(1'b0, 2'd0, 4'b0000);
    for (int i = 1; i <= TO; i++) begin
      step("wd_wait_ren", 4'b0000);
      check($sformatf("wd_timeout_after_%0d", i), DW'(bus.o_timeout_err), DW'(i == TO));
    end
    drive(1'b0, 2'd0, 4'b0010); step("wd_ren_bc1", 4'b0010);
    drive(1'b0, 2'd0, 4'b0000); step("wd_idle", 4'b0000);
    check("wd_timeout_sticky", DW'(bus.o_timeout_err), DW'(1));
    check("wd_scoreboard", DW'(exp_q.size()), DW'(0));

    // ---------------- asynchronous reset mid-stream ----------------
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'd3, 4'b0000);
      step("ar_issue_ren", 4'b0000);
    end
    drive(1'b0, 2'd0, 4'b0000);
    check("ar_before_empty", DW'(bus.o_order_empty), DW'(0));
    #2 rst_n = 1'b0;
    drive(1'b0, 2'd0, 4'b1111);
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step("ar_after_ren", 4'b0000);
    check("ar_after_valid", DW'(bus.o_read_data_valid), DW'(0));
    check("ar_after_empty", DW'(bus.o_order_empty), DW'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_read_return_sequencer
